seq_bin2bcd: RTL and testbench

SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/seq_bin2bcd_digit_adj.sv | 22 ++
 rtl/seq_bin2bcd.sv | 173 +++++++++++++++++
 tb/tb_seq_bin2bcd.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter (FSM state encoding, digit width, add-3 rule).
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

    // Width of one packed BCD digit
    localparam int DIGIT_W     = 4;
    // A digit at or above this value is corrected before the next shift
    localparam int ADD3_THRESH = 5;
    // Correction added so that doubling carries cleanly into the next digit
    localparam int ADD3_VAL    = 3;

    // Converter control states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/seq_bin2bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction. A digit of 5 or more gets +3
//               so that the following left shift produces a decimal carry.
//               Inputs are always legal BCD (0..9), so the sum never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    localparam logic [DIGIT_W-1:0] c_thresh = DIGIT_W'(ADD3_THRESH);
    localparam logic [DIGIT_W-1:0] c_add    = DIGIT_W'(ADD3_VAL);

    assign digit_out = (digit_in >= c_thresh) ? (digit_in + c_add) : digit_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin2bcd
// Description : Sequential (one bit per clock) binary-to-packed-BCD converter
//               using the shift-and-add-3 algorithm. A conversion takes BIN_W
//               clocks from the accepting edge; results are registered and held
//               until the next completion. Values that do not fit in DIGITS
//               decimal digits are reported modulo 10**DIGITS with overflow set.
//               Optional leading-zero mask output enabled by the macro
//               BIN2BCD_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] bcd_out,
    output logic                      overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int                  c_bcd_w    = DIGITS * DIGIT_W;
    localparam int                  c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_digits;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_digits_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf_acc;
    logic                 w_ovf_nxt;
    logic                 w_accept;
    logic                 w_last;
    logic                 r_done;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf;

    // Per-digit add-3 correction ahead of each shift
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_in  (r_digits[gi*DIGIT_W +: DIGIT_W]),
            .digit_out (w_adj[gi*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digit chain shifted left with the next binary MSB entering at
    // bit 0; the bit leaving the top digit is a lost decimal carry, so any such
    // bit means the value does not fit in DIGITS digits.
    assign w_digits_nxt = {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
    assign w_ovf_nxt    = r_ovf_acc | w_adj[c_bcd_w-1];

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working datapath: load on accept, then one shift per clock in SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin     <= '0;
            r_digits  <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_bin     <= bin_in;
            r_digits  <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= c_cnt_load;
        end else if (r_state == ST_SHIFT) begin
            r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
            r_digits  <= w_digits_nxt;
            r_ovf_acc <= w_ovf_nxt;
            r_cnt     <= r_cnt - c_cnt_w'(1);
        end
    end

    // Result registers and one-cycle done pulse, captured from the final shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_bcd <= w_digits_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign busy     = (r_state == ST_SHIFT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

`ifdef BIN2BCD_BLANK_EN
    // Reset mask: every digit above digit 0 blanked (displays a single "0")
    localparam logic [DIGITS-1:0] c_blank_rst = ~(DIGITS'(1));

    logic [DIGITS-1:0] w_blank;
    logic              w_zero_above;
    logic [DIGITS-1:0] r_blank;

    // Leading-zero mask of the final digits, scanning down from the top digit
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero_above = w_zero_above &
                           (w_digits_nxt[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(0));
            w_blank[i]   = w_zero_above;
        end
    end

    // Mask register, updated together with bcd_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank <= c_blank_rst;
        end else if (w_last) begin
            r_blank <= w_blank;
        end
    end

    assign blank = r_blank;
`else
    // No leading-zero mask in this build
`endif

endmodule : seq_bin2bcd
`default_nettype wire

// File: tb/tb_seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_bin2bcd
// Description : Self-checking bench for seq_bin2bcd. Five instances cover the
//               parameter sets 12/4, 8/3, 20/7, 4/1 and 14/4. Results are
//               compared against a decimal reference model (mod / divide).
//               Leading-zero mask checks follow the BIN2BCD_BLANK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bin2bcd;

    localparam int N_INST = 5;

    function automatic int bw_of(input int i);
        case (i)
            0: return 12;
            1: return 8;
            2: return 20;
            3: return 4;
            default: return 14;
        endcase
    endfunction

    function automatic int dg_of(input int i);
        case (i)
            0: return 4;
            1: return 3;
            2: return 7;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst;
    logic [N_INST-1:0] st_v;
    logic [31:0]       bin_a   [N_INST];
    logic [N_INST-1:0] busy_v;
    logic [N_INST-1:0] done_v;
    logic [N_INST-1:0] ovf_v;
    logic [39:0]       bcd_a   [N_INST];
`ifdef BIN2BCD_BLANK_EN
    logic [9:0]        blank_a [N_INST];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        localparam int W = bw_of(g);
        localparam int D = dg_of(g);
        logic [4*D-1:0] bcd_l;
`ifdef BIN2BCD_BLANK_EN
        logic [D-1:0]   blank_l;
`endif
        seq_bin2bcd #(.BIN_W(W), .DIGITS(D)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (st_v[g]),
            .bin_in   (bin_a[g][W-1:0]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .bcd_out  (bcd_l),
            .overflow (ovf_v[g])
`ifdef BIN2BCD_BLANK_EN
            ,
            .blank    (blank_l)
`endif
        );
        assign bcd_a[g] = 40'(bcd_l);
`ifdef BIN2BCD_BLANK_EN
        assign blank_a[g] = 10'(blank_l);
`endif
    end

    // ---------------- reference model ----------------
    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input longint v, input int d);
        longint      m = v % pow10(d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_ovf(input longint v, input int d);
        return (v >= pow10(d)) ? 64'd1 : 64'd0;
    endfunction

    // digit i is blank when the low-d-digit residue has no digit at or above i
    function automatic logic [63:0] ref_blank(input longint v, input int d);
        longint      m = v % pow10(d);
        logic [63:0] r = '0;
        for (int i = 1; i < d; i++) r[i] = (m < pow10(i));
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One conversion on instance idx; caller guarantees the instance is idle
    task automatic convert(input int idx, input logic [31:0] v_in);
        int          w;
        int          d;
        int          lat;
        logic [31:0] v;
        w   = bw_of(idx);
        d   = dg_of(idx);
        v   = v_in & ((32'h1 << w) - 32'h1);
        bin_a[idx] = v;
        st_v[idx]  = 1'b1;
        @(posedge clk);
        #1;
        st_v[idx]  = 1'b0;
        bin_a[idx] = $urandom;
        check_eq("busy_after_accept", 64'(busy_v[idx]), 64'd1);
        lat = -1;
        for (int e = 1; e <= 64 && lat < 0; e++) begin
            @(posedge clk);
            #1;
            if (done_v[idx]) lat = e;
        end
        check_eq("latency", 64'(lat), 64'(w));
        check_eq("bcd", 64'(bcd_a[idx]), ref_bcd(longint'(v), d));
        check_eq("overflow", 64'(ovf_v[idx]), ref_ovf(longint'(v), d));
        check_eq("busy_in_done", 64'(busy_v[idx]), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        check_eq("blank", 64'(blank_a[idx]), ref_blank(longint'(v), d));
`endif
    endtask

    initial begin
        int          ndone;
        int          first;
        int          seen;
        int          bound;
        logic [63:0] got;
        int          d_at[$];

        st_v = '0;
        for (int i = 0; i < N_INST; i++) bin_a[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_busy", 64'(busy_v[0]), 64'd0);
        check_eq("rst_done", 64'(done_v[0]), 64'd0);
        check_eq("rst_bcd", 64'(bcd_a[0]), 64'd0);
        check_eq("rst_ovf", 64'(ovf_v[0]), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        check_eq("rst_blank", 64'(blank_a[0]), 64'b1110);
`endif
        rst = 1'b0;

        // directed values, default parameters
        convert(0, 32'd4095);
        check_eq("4095_hex", 64'(bcd_a[0]), 64'h4095);
        convert(0, 32'd0);
        convert(0, 32'd2024);
        check_eq("2024_hex", 64'(bcd_a[0]), 64'h2024);

        // 14-bit / 4-digit overflow boundary
        convert(4, 32'd12345);
        check_eq("12345_hex", 64'(bcd_a[4]), 64'h2345);
        check_eq("12345_ovf", 64'(ovf_v[4]), 64'd1);
        convert(4, 32'd9999);
        convert(4, 32'd10000);
        convert(4, 32'd16383);

        // start pulses while busy are ignored
        bin_a[0] = 32'd321;
        st_v[0]  = 1'b1;
        @(posedge clk);
        #1;
        st_v[0]  = 1'b0;
        bin_a[0] = 32'd999;
        ndone = 0;
        first = -1;
        got   = '0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                ndone++;
                if (first < 0) begin
                    first = e;
                    got   = 64'(bcd_a[0]);
                end
            end
            st_v[0] = (e == 2 || e == 6);
            if (e == 2 || e == 6) bin_a[0] = $urandom_range(0, 4095);
        end
        check_eq("ign_done_count", 64'(ndone), 64'd1);
        check_eq("ign_latency", 64'(first), 64'd12);
        check_eq("ign_bcd", got, ref_bcd(64'd321, 4));

        // start held high: a new conversion is accepted in each done cycle
        bin_a[0] = 32'd777;
        st_v[0]  = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                d_at.push_back(e);
                check_eq("b2b_bcd", 64'(bcd_a[0]), 64'h0777);
            end
        end
        st_v[0] = 1'b0;
        check_eq("b2b_done_count", 64'(d_at.size()), 64'd3);
        if (d_at.size() == 3) begin
            check_eq("b2b_first", 64'(d_at[0]), 64'd12);
            check_eq("b2b_period1", 64'(d_at[1] - d_at[0]), 64'd13);
            check_eq("b2b_period2", 64'(d_at[2] - d_at[1]), 64'd13);
        end
        bound = 0;
        while (busy_v[0] && bound < 40) begin
            @(posedge clk);
            #1;
            bound++;
        end
        check_eq("b2b_drain", 64'(busy_v[0]), 64'd0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a conversion
        convert(0, 32'd2024);
        bin_a[0] = 32'd4095;
        st_v[0]  = 1'b1;
        @(posedge clk);
        #1;
        st_v[0]  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", 64'(busy_v[0]), 64'd0);
        check_eq("mrst_done", 64'(done_v[0]), 64'd0);
        check_eq("mrst_bcd", 64'(bcd_a[0]), 64'd0);
        check_eq("mrst_ovf", 64'(ovf_v[0]), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        check_eq("mrst_blank", 64'(blank_a[0]), 64'b1110);
`endif
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen = 1;
        end
        check_eq("mrst_no_done", 64'(seen), 64'd0);
        convert(0, 32'd59);
        check_eq("59_hex", 64'(bcd_a[0]), 64'h0059);

        // random sweeps with boundary values first
        for (int idx = 0; idx < 4; idx++) begin
            convert(idx, 32'd0);
            convert(idx, 32'hFFFF_FFFF);
            for (int n = 0; n < 1000; n++) convert(idx, $urandom);
        end
        for (int n = 0; n < 200; n++) convert(4, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_bin2bcd
`default_nettype wire
